// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE stage (ALU, branch target, destination select) feeding the EX/MEM register.
// Define EXE_MUL_EN to build the iterative shift-add multiplier (aluOp 11) that stalls the pipe via busy.
module exe_mem_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic        flush,
    input  logic [31:0] pcPlus4In,
    input  logic [31:0] imm32In,
    input  logic [31:0] shamt32In,
    input  logic [31:0] regData1In,
    input  logic [31:0] regData2In,
    input  logic [4:0]  instrRtIn,
    input  logic [4:0]  instrRdIn,
    input  logic [3:0]  aluOpIn,
    input  logic        aluSrcIn,
    input  logic        regDstIn,
    input  logic        regWriteIn,
    input  logic        branchIn,
    input  logic        memToRegIn,
    input  logic        memWriteIn,
    input  logic        memReadIn,
    input  logic        loadFullWordIn,
    input  logic        loadSignedIn,
    output logic [31:0] branchTargetOut,
    output logic [31:0] aluResultOut,
    output logic [31:0] storeDataOut,
    output logic [4:0]  destRegOut,
    output logic        zeroOut,
    output logic        regWriteOut,
    output logic        branchOut,
    output logic        memToRegOut,
    output logic        memWriteOut,
    output logic        memReadOut,
    output logic        loadFullWordOut,
    output logic        loadSignedOut,
    output logic        busy
);
    logic [31:0] op_a, op_b, alu_res, result;
    logic [4:0]  sh;
    logic        bubble;
    logic        shamt_unused;

    assign op_a = regData1In;
    assign op_b = aluSrcIn ? imm32In : regData2In;
    assign sh = shamt32In[4:0];
    assign shamt_unused = ^shamt32In[31:5];

    always_comb begin
        case (aluOpIn)
            4'd0:    alu_res = op_a & op_b;
            4'd1:    alu_res = op_a | op_b;
            4'd2:    alu_res = op_a + op_b;
            4'd3:    alu_res = op_a ^ op_b;
            4'd4:    alu_res = regData2In << sh;
            4'd5:    alu_res = regData2In >> sh;
            4'd6:    alu_res = op_a - op_b;
            4'd7:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd8:    alu_res = {31'd0, op_a < op_b};
            4'd9:    alu_res = ~(op_a | op_b);
            4'd10:   alu_res = $unsigned($signed(regData2In) >>> sh);
            default: alu_res = 32'd0;
        endcase
    end

`ifdef EXE_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t      state;
    logic [31:0] mul_a, mul_b, prod;
    logic [5:0]  cnt;
    logic        start;

    // busy rises combinationally so the hazard unit freezes the MUL in ID/EXE at once
    assign start = reset && state == IDLE && aluOpIn == 4'd11 && !flush;
    assign busy = start || state == MUL;
    assign bubble = flush || start || state == MUL;
    assign result = state == DONE ? prod : alu_res;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 6'd0;
            mul_a <= 32'd0;
            mul_b <= 32'd0;
            prod <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
            cnt <= 6'd0;
            prod <= 32'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mul_a <= op_a;
                    mul_b <= op_b;
                    prod <= 32'd0;
                    cnt <= 6'd0;
                    state <= MUL;
                end
                MUL: begin
                    prod <= mul_b[0] ? prod + mul_a : prod;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(MUL_CYCLES - 1)) state <= DONE;
                end
                DONE: if (write) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy = 1'b0;
    assign bubble = flush;
    assign result = alu_res;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || ((flush || write) && bubble)) begin
            branchTargetOut <= 32'd0;
            aluResultOut <= 32'd0;
            storeDataOut <= 32'd0;
            destRegOut <= 5'd0;
            zeroOut <= 1'b0;
            regWriteOut <= 1'b0;
            branchOut <= 1'b0;
            memToRegOut <= 1'b0;
            memWriteOut <= 1'b0;
            memReadOut <= 1'b0;
            loadFullWordOut <= 1'b0;
            loadSignedOut <= 1'b0;
        end else if (write) begin
            branchTargetOut <= pcPlus4In + {imm32In[29:0], 2'b00};
            aluResultOut <= result;
            storeDataOut <= regData2In;
            destRegOut <= regDstIn ? instrRdIn : instrRtIn;
            zeroOut <= result == 32'd0;
            regWriteOut <= regWriteIn;
            branchOut <= branchIn;
            memToRegOut <= memToRegIn;
            memWriteOut <= memWriteIn;
            memReadOut <= memReadIn;
            loadFullWordOut <= loadFullWordIn;
            loadSignedOut <= loadSignedIn;
        end
    end
endmodule
